// File: rtl/mem_access_if.sv
// Purpose: request/response, data-memory and debug-counter bundle for the MEM-stage unit.
// Latency: none, wires only.
// Backpressure: req_ready from the slave side stalls the requester.
interface mem_access_if #(
   parameter int COUNT_W = 16
);
   // request from EX/MEM
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [1:0]         req_size;
   logic               req_unsigned;
   logic [31:0]        req_addr;
   logic [31:0]        req_wdata;
   // response
   logic               rsp_valid;
   logic [31:0]        rsp_rdata;
   logic               rsp_err;
   // word-wide data memory
   logic [31:0]        mem_A;
   logic [31:0]        mem_WD;
   logic               mem_WE;
   logic [31:0]        mem_RD;
   // debug counters
   logic [COUNT_W-1:0] load_cnt;
   logic [COUNT_W-1:0] store_cnt;
   logic [COUNT_W-1:0] err_cnt;

   // side of the load/store unit
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE,
      output load_cnt, store_cnt, err_cnt
   );

   // side of the pipeline / memory / probes
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE,
      input  load_cnt, store_cnt, err_cnt
   );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store initiator; lane extract/extend for loads, read-modify-write for sub-word stores.
// Latency: accept to rsp_valid = load 2, word store 2, sub-word store 3, error 1 cycles.
// Backpressure: req_ready is low from accept until the unit is back in IDLE; requests are ignored meanwhile.
module mem_access_unit #(
   parameter bit BIG_ENDIAN = 1'b0,
   parameter int COUNT_W    = 16
) (
   input  logic         clk,
   input  logic         rst,
   mem_access_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, LOAD, ST_W, RMW_RD, RMW_WR, RESP} state_t;

   state_t             state;
   logic               ready_q;
   logic               rsp_valid_q;
   logic               rsp_err_q;
   logic [31:0]        rdata_q;
   logic [31:0]        a_q;
   logic [31:0]        wd_q;
   logic               we_q;
   logic               op_we;
   logic               op_uns;
   logic [1:0]         op_size;
   logic [1:0]         op_lane;
   logic [15:0]        op_wdata;
   logic [COUNT_W-1:0] load_cnt_q;
   logic [COUNT_W-1:0] store_cnt_q;
   logic [COUNT_W-1:0] err_cnt_q;

   logic               req_err;
   logic [1:0]         byte_sel;
   logic               half_sel;
   logic [7:0]         byte_val;
   logic [15:0]        half_val;
   logic [31:0]        load_val;
   logic [31:0]        merged;

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.mem_A     = a_q;
   assign bus.mem_WD    = wd_q;
   assign bus.mem_WE    = we_q;
   assign bus.load_cnt  = load_cnt_q;
   assign bus.store_cnt = store_cnt_q;
   assign bus.err_cnt   = err_cnt_q;

   // misaligned half/word or the reserved size code is rejected at accept
   always_comb begin
      req_err = 1'b0;
      case (bus.req_size)
         2'b01:   req_err = bus.req_addr[0];
         2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
         2'b11:   req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
   end

   // lane selection, load extension and store merge against the word currently on mem_RD
   always_comb begin
      byte_sel = BIG_ENDIAN ? ~op_lane : op_lane;
      half_sel = BIG_ENDIAN ? ~op_lane[1] : op_lane[1];
      byte_val = bus.mem_RD[{byte_sel, 3'b000} +: 8];
      half_val = bus.mem_RD[{half_sel, 4'b0000} +: 16];
      load_val = bus.mem_RD;
      case (op_size)
         2'b00:   load_val = op_uns ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
         2'b01:   load_val = op_uns ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
         default: load_val = bus.mem_RD;
      endcase
      merged = bus.mem_RD;
      if (op_size == 2'b00) begin
         merged[{byte_sel, 3'b000} +: 8] = op_wdata[7:0];
      end else begin
         merged[{half_sel, 4'b0000} +: 16] = op_wdata[15:0];
      end
   end

   // control FSM with registered outputs; reset aborts any operation and drops mem_WE at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= 32'h0;
         a_q         <= 32'h0;
         wd_q        <= 32'h0;
         we_q        <= 1'b0;
         op_we       <= 1'b0;
         op_uns      <= 1'b0;
         op_size     <= 2'b00;
         op_lane     <= 2'b00;
         op_wdata    <= 16'h0;
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && ready_q) begin
                  ready_q  <= 1'b0;
                  op_we    <= bus.req_we;
                  op_uns   <= bus.req_unsigned;
                  op_size  <= bus.req_size;
                  op_lane  <= bus.req_addr[1:0];
                  op_wdata <= bus.req_wdata[15:0];
                  a_q      <= {2'b00, bus.req_addr[31:2]};
                  rdata_q  <= 32'h0;
                  if (req_err) begin
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state       <= RESP;
                  end else if (!bus.req_we) begin
                     state <= LOAD;
                  end else if (bus.req_size == 2'b10) begin
                     wd_q  <= bus.req_wdata;
                     we_q  <= 1'b1;
                     state <= ST_W;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            LOAD: begin
               rdata_q     <= load_val;
               rsp_valid_q <= 1'b1;
               state       <= RESP;
            end
            ST_W: begin
               we_q        <= 1'b0;
               rsp_valid_q <= 1'b1;
               state       <= RESP;
            end
            RMW_RD: begin
               wd_q  <= merged;
               we_q  <= 1'b1;
               state <= RMW_WR;
            end
            RMW_WR: begin
               we_q        <= 1'b0;
               rsp_valid_q <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rdata_q     <= 32'h0;
               ready_q     <= 1'b1;
               state       <= IDLE;
               if (rsp_err_q) begin
                  if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
               end else if (op_we) begin
                  if (!(&store_cnt_q)) store_cnt_q <= store_cnt_q + 1'b1;
               end else begin
                  if (!(&load_cnt_q)) load_cnt_q <= load_cnt_q + 1'b1;
               end
            end
            default: begin
               we_q    <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: directed bench for mem_access_unit with a 32-word behavioural data memory.
// Latency: measured per request from the accept edge to the rsp_valid cycle.
// Backpressure: requests are presented only while req_ready is high, except in the held-valid sequence.
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic init_mem = 1'b1;

   always #5 clk = ~clk;

   mem_access_if #(.COUNT_W(16)) bus();

   mem_access_unit #(.BIG_ENDIAN(1'b0), .COUNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [0:31];
   int we_cycles = 0;
   int rsp_pulses = 0;

   assign bus.mem_RD = (bus.mem_A < 32) ? mem[bus.mem_A[4:0]] : 32'h0;

   // memory: word i resets to i; synchronous write
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 32; i++) mem[i] <= i;
      end else if (bus.mem_WE && (bus.mem_A < 32)) begin
         mem[bus.mem_A[4:0]] <= bus.mem_WD;
      end
   end

   // activity monitor for write-enable cycles and response pulses
   always @(posedge clk) begin
      if (bus.mem_WE) we_cycles <= we_cycles + 1;
      if (bus.rsp_valid) rsp_pulses <= rsp_pulses + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         checks++;
         errors++;
         $error("FAIL ready_timeout: observed req_ready=0 expected 1");
      end
   endtask

   // one request from an IDLE negedge; returns at the negedge where rsp_valid is seen
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
      wait_ready();
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
      if (!bus.rsp_valid) begin
         checks++;
         errors++;
         $error("FAIL rsp_timeout: observed rsp_valid=0 expected 1 (addr %h)", addr);
      end
   endtask

   // held-valid sequence: sw, lw, sb lane 3, lb lane 3, lhu upper half on word 4
   logic        v_we    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [1:0]  v_size  [5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
   logic        v_uns   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] v_addr  [5] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h12};
   logic [31:0] v_wdata [5] = '{32'h0A0B0C0D, 32'h0, 32'h000000EE, 32'h0, 32'h0};
   logic [31:0] v_exp   [5] = '{32'h0, 32'h0A0B0C0D, 32'h0, 32'hFFFFFFEE, 32'h0000EE0B};

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          we0;
      int          rp0;
      int          nacc;
      int          nrsp;
      int          cyc;
      int          acc_cyc [5];
      logic [31:0] got [5];

      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_err",   {31'h0, bus.rsp_err}, 32'h0);
      check("rst_mem_WE",    {31'h0, bus.mem_WE}, 32'h0);
      check("rst_mem_A",     bus.mem_A, 32'h0);
      check("rst_mem_WD",    bus.mem_WD, 32'h0);
      check("rst_cnts",      {bus.load_cnt, bus.store_cnt} | {16'h0, bus.err_cnt}, 32'h0);
      init_mem = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // word load of reset memory contents
      do_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, rd, er, lat);
      check("lw_1c_data", rd, 32'h00000007);
      check("lw_1c_err",  {31'h0, er}, 32'h0);
      check("lw_1c_lat",  lat, 2);

      // word store, then byte store merged by read-modify-write
      we0 = we_cycles;
      do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, rd, er, lat);
      check("sw_lat",   lat, 2);
      check("sw_rdata", rd, 32'h0);
      check("sw_we_cycles", we_cycles - we0, 1);
      we0 = we_cycles;
      do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AB, rd, er, lat);
      check("sb_lat", lat, 3);
      check("sb_we_cycles", we_cycles - we0, 1);
      check("sb_word2", mem[2], 32'h1122AB44);

      // sub-word loads from the merged word
      do_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, rd, er, lat);
      check("lhu_0a", rd, 32'h00001122);
      do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, rd, er, lat);
      check("lb_09", rd, 32'hFFFFFFAB);

      // sign/zero extension on 0x80
      do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h00000080, rd, er, lat);
      do_req(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, rd, er, lat);
      check("lb_08",  rd, 32'hFFFFFF80);
      check("lb_lat", lat, 2);
      do_req(1'b0, 2'b00, 1'b1, 32'h08, 32'h0, rd, er, lat);
      check("lbu_08", rd, 32'h00000080);
      do_req(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, rd, er, lat);
      check("lh_08",  rd, 32'h00000080);

      // misaligned requests
      we0 = we_cycles;
      do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, er, lat);
      check("lw_06_err",   {31'h0, er}, 32'h1);
      check("lw_06_rdata", rd, 32'h0);
      check("lw_06_lat",   lat, 1);
      do_req(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, rd, er, lat);
      check("lh_05_err",   {31'h0, er}, 32'h1);
      check("lh_05_rdata", rd, 32'h0);
      @(negedge clk);
      check("err_we_cycles", we_cycles - we0, 0);
      check("err_cnt",   {16'h0, bus.err_cnt}, 32'd2);
      check("load_cnt",  {16'h0, bus.load_cnt}, 32'd6);
      check("store_cnt", {16'h0, bus.store_cnt}, 32'd3);

      // reset asserted during RMW_RD of a byte store
      wait_ready();
      we0 = we_cycles;
      rp0 = rsp_pulses;
      bus.req_we       = 1'b1;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h08;
      bus.req_wdata    = 32'h000000CD;
      bus.req_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("abort_busy", {31'h0, bus.req_ready}, 32'h0);
      rst = 1'b0;
      #1;
      check("abort_mem_WE",    {31'h0, bus.mem_WE}, 32'h0);
      check("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("abort_word2",      mem[2], 32'h00000080);
      check("abort_we_cycles",  we_cycles - we0, 0);
      check("abort_no_rsp",     rsp_pulses - rp0, 0);
      check("abort_ready_after", {31'h0, bus.req_ready}, 32'h1);
      check("abort_load_cnt",   {16'h0, bus.load_cnt}, 32'd0);

      // req_valid held high across five requests; fields are garbage while busy
      we0  = we_cycles;
      rp0  = rsp_pulses;
      nacc = 0;
      nrsp = 0;
      cyc  = 0;
      while ((nacc < 5 || nrsp < 5) && cyc < 80) begin
         if (nacc < 5 && bus.req_ready) begin
            bus.req_we       = v_we[nacc];
            bus.req_size     = v_size[nacc];
            bus.req_unsigned = v_uns[nacc];
            bus.req_addr     = v_addr[nacc];
            bus.req_wdata    = v_wdata[nacc];
            bus.req_valid    = 1'b1;
            acc_cyc[nacc]    = cyc;
            nacc++;
         end else if (nacc < 5) begin
            bus.req_we    = 1'b1;
            bus.req_size  = 2'b10;
            bus.req_addr  = 32'h0;
            bus.req_wdata = 32'hFFFFFFFF;
            bus.req_valid = 1'b1;
         end else begin
            bus.req_valid = 1'b0;
         end
         if (bus.rsp_valid && nrsp < 5) begin
            got[nrsp] = bus.rsp_rdata;
            nrsp++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("b2b_responses", nrsp, 5);
      check("b2b_rsp_pulses", rsp_pulses - rp0, 5);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("b2b_rdata%0d", k), got[k], v_exp[k]);
      end
      check("b2b_spacing_sw", acc_cyc[1] - acc_cyc[0], 3);
      check("b2b_spacing_sb", acc_cyc[3] - acc_cyc[2], 4);
      check("b2b_we_cycles", we_cycles - we0, 2);
      check("b2b_word4", mem[4], 32'hEE0B0C0D);
      check("b2b_word0_untouched", mem[0], 32'h0);
      check("b2b_load_cnt",  {16'h0, bus.load_cnt}, 32'd3);
      check("b2b_store_cnt", {16'h0, bus.store_cnt}, 32'd2);
      check("b2b_err_cnt",   {16'h0, bus.err_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
